// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the core pipeline: stall encodings, reset level,
// stall-vector width, per-stage indices and the register's per-edge action.
package pipe_stage_reg_pkg;

  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic RESET_ENABLE = 1'b1;

  localparam int          STALL_W   = 6;
  localparam logic [63:0] ZERO_WORD = 64'h0;

  localparam int STAGE_PC  = 0;
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_LOAD,
    ACT_HOLD
  } act_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous reset and clear.
// Clear beats a same-cycle increment; the count never wraps.
module sat_counter
  import pipe_stage_reg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload + valid, driven by the global
// stall vector, with flush and saturating hold/bubble profiling counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W  = 64,
  parameter int                STALL_W = 6,
  parameter int                STAGE   = 1,
  parameter logic [DATA_W-1:0] BUBBLE  = '0,
  parameter int                CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic up;
  logic dn;
  act_e act;

  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];

  // Overlapping conditions: earlier items take precedence.
  always_comb begin
    act = ACT_HOLD;
    priority case (1'b1)
      rst == RESET_ENABLE:         act = ACT_RESET;
      flush:                       act = ACT_FLUSH;
      up == STOP && dn == NO_STOP: act = ACT_BUBBLE;
      up == NO_STOP:               act = ACT_LOAD;
      default:                     act = ACT_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    unique case (act)
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
        out_valid <= 1'b0;
        out_data  <= BUBBLE;
      end
      ACT_LOAD: begin
        out_valid <= in_valid;
        out_data  <= in_data;
      end
      default: begin
        out_valid <= out_valid;
        out_data  <= out_data;
      end
    endcase
  end

  logic hold_ev;
  logic bubble_ev;

  assign hold_ev   = (act == ACT_HOLD);
  assign bubble_ev = (act == ACT_FLUSH) || (act == ACT_BUBBLE);

  sat_counter #(.CNT_W(CNT_W)) u_hold (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (hold_ev),
    .cnt (hold_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (bubble_ev),
    .cnt (bubble_cnt)
  );

  // The stall controller never lets downstream stop while upstream runs.
  a_stall_legal: assert property (
    @(posedge clk) disable iff (rst)
    !(up == NO_STOP && dn == STOP)
  );

endmodule
